// File: rtl/pipelined_segmented_adder_pkg.sv
// Shared definitions for pipelined_segmented_adder.
//   - default widths
//   - ceil_div / num_stages / last_seg_width derivations
//   - params_ok legality check used at elaboration time
// Optional feature macro: PIPELINED_ADDER_SIGN_EXT_EN (see pipelined_segmented_adder.sv).
package pipelined_segmented_adder_pkg;

    localparam int unsigned DEF_A_WIDTH   = 63;
    localparam int unsigned DEF_B_WIDTH   = 59;
    localparam int unsigned DEF_SEG_WIDTH = 16;

    // Guarded against a zero divisor so an illegal SEG_WIDTH reaches the
    // legality check instead of dying in a division.
    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        if (den == 0) return 1;
        return (num + den - 1) / den;
    endfunction

    function automatic int unsigned num_stages(input int unsigned a_w, input int unsigned seg_w);
        return ceil_div(a_w, seg_w);
    endfunction

    function automatic int unsigned last_seg_width(input int unsigned a_w, input int unsigned seg_w);
        return a_w - (num_stages(a_w, seg_w) - 1) * seg_w;
    endfunction

    function automatic bit params_ok(input int unsigned a_w, input int unsigned b_w,
                                     input int unsigned seg_w);
        return (b_w >= 1) && (b_w <= a_w) && (seg_w >= 1) && (seg_w <= a_w);
    endfunction

endpackage

// File: rtl/pipelined_segmented_adder_if.sv
// Operand/result handshake bundle for pipelined_segmented_adder.
//   in_valid/in_ready/A/B/cin : operand transfer (producer -> adder)
//   out_valid/out_ready/Sum   : result transfer (adder -> consumer)
// master = producer/consumer side, slave = adder side.
interface pipelined_segmented_adder_if #(
    parameter int unsigned A_WIDTH = pipelined_segmented_adder_pkg::DEF_A_WIDTH,
    parameter int unsigned B_WIDTH = pipelined_segmented_adder_pkg::DEF_B_WIDTH
);
    logic               in_valid;
    logic               in_ready;
    logic [A_WIDTH-1:0] A;
    logic [B_WIDTH-1:0] B;
    logic               cin;
    logic               out_valid;
    logic               out_ready;
    logic [A_WIDTH:0]   Sum;

    modport master (
        output in_valid, A, B, cin, out_ready,
        input  in_ready, out_valid, Sum
    );

    modport slave (
        input  in_valid, A, B, cin, out_ready,
        output in_ready, out_valid, Sum
    );
endinterface

// File: rtl/pipelined_segmented_adder_segment_stage.sv
// One carry-chain segment of pipelined_segmented_adder.
//   clk, rst     : clock, synchronous active-high reset
//   en           : global advance; all registers hold when low
//   in_valid     : valid bit travelling with this segment's operands
//   a, b, cin    : segment operands and incoming carry
//   sum, cout    : registered segment sum and carry-out
//   out_valid    : registered valid bit
module adder_segment_stage #(
    parameter int unsigned SEG_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout,
    output logic             out_valid
);
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            {cout, sum} <= {1'b0, a} + {1'b0, b} + (SEG_W + 1)'(cin);
            out_valid   <= in_valid;
        end
    end
endmodule

// File: rtl/pipelined_segmented_adder.sv
// Pipelined A_WIDTH + B_WIDTH adder, one SEG_WIDTH-bit carry segment per stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pipelined_segmented_adder_if.slave
//              in_valid/in_ready/A/B/cin in, out_valid/out_ready/Sum out
// Sum = A + ext(B) + cin, (A_WIDTH+1) bits, latency NUM_STAGES without stalls.
// Optional macro PIPELINED_ADDER_SIGN_EXT_EN: B sign-extended, A signed, Sum MSB
// is the sign of the signed result rather than the raw carry-out.
module pipelined_segmented_adder
    import pipelined_segmented_adder_pkg::*;
#(
    parameter int unsigned A_WIDTH   = DEF_A_WIDTH,
    parameter int unsigned B_WIDTH   = DEF_B_WIDTH,
    parameter int unsigned SEG_WIDTH = DEF_SEG_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    pipelined_segmented_adder_if.slave  bus
);
    localparam int unsigned NUM_STAGES = num_stages(A_WIDTH, SEG_WIDTH);
    localparam int unsigned LAST_W     = last_seg_width(A_WIDTH, SEG_WIDTH);
    localparam int unsigned LAST_LO    = (NUM_STAGES - 1) * SEG_WIDTH;

    if (!params_ok(A_WIDTH, B_WIDTH, SEG_WIDTH)) begin : g_bad_params
        $error("pipelined_segmented_adder: illegal A_WIDTH/B_WIDTH/SEG_WIDTH");
    end

    logic                 advance;
    logic [A_WIDTH-1:0]   ext_a;
    logic [A_WIDTH-1:0]   ext_b;

    // Per-stage views: op_* are the operand words presented to stage k,
    // lo_in the already-finished lower sum bits presented alongside them.
    logic [A_WIDTH-1:0]   op_a  [NUM_STAGES];
    logic [A_WIDTH-1:0]   op_b  [NUM_STAGES];
    logic [A_WIDTH-1:0]   lo_in [NUM_STAGES];
    logic                 c_in  [NUM_STAGES];
    logic                 v_in  [NUM_STAGES];

    // Skew/deskew registers, captured alongside each stage's own registers.
    logic [A_WIDTH-1:0]   a_q   [NUM_STAGES];
    logic [A_WIDTH-1:0]   b_q   [NUM_STAGES];
    logic [A_WIDTH-1:0]   lo_q  [NUM_STAGES];

    logic [SEG_WIDTH-1:0] seg_sum [NUM_STAGES];
    logic                 carry   [NUM_STAGES];
    logic                 vld     [NUM_STAGES];

    logic [A_WIDTH-1:0]   sum_body;
    logic                 sum_msb;

    assign ext_a = bus.A;
`ifdef PIPELINED_ADDER_SIGN_EXT_EN
    assign ext_b = A_WIDTH'(signed'(bus.B));
`else
    assign ext_b = A_WIDTH'(bus.B);
`endif

    assign advance      = !vld[NUM_STAGES-1] || bus.out_ready;
    assign bus.in_ready = advance;

    always_comb begin
        op_a[0]  = ext_a;
        op_b[0]  = ext_b;
        lo_in[0] = '0;
        c_in[0]  = bus.cin;
        v_in[0]  = bus.in_valid;
        for (int unsigned k = 1; k < NUM_STAGES; k++) begin
            op_a[k]  = a_q[k-1];
            op_b[k]  = b_q[k-1];
            lo_in[k] = lo_q[k-1] | (A_WIDTH'(seg_sum[k-1]) << ((k - 1) * SEG_WIDTH));
            c_in[k]  = carry[k-1];
            v_in[k]  = vld[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                a_q[k]  <= '0;
                b_q[k]  <= '0;
                lo_q[k] <= '0;
            end
        end else if (advance) begin
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                a_q[k]  <= op_a[k];
                b_q[k]  <= op_b[k];
                lo_q[k] <= lo_in[k];
            end
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam int unsigned W  = (k == NUM_STAGES - 1) ? LAST_W : SEG_WIDTH;
        localparam int unsigned LO = k * SEG_WIDTH;
        logic [W-1:0] s;

        adder_segment_stage #(.SEG_W(W)) u_seg (
            .clk       (clk),
            .rst       (rst),
            .en        (advance),
            .in_valid  (v_in[k]),
            .a         (op_a[k][LO +: W]),
            .b         (op_b[k][LO +: W]),
            .cin       (c_in[k]),
            .sum       (s),
            .cout      (carry[k]),
            .out_valid (vld[k])
        );

        assign seg_sum[k] = SEG_WIDTH'(s);
    end

    assign sum_body = lo_q[NUM_STAGES-1] | (A_WIDTH'(seg_sum[NUM_STAGES-1]) << LAST_LO);

`ifdef PIPELINED_ADDER_SIGN_EXT_EN
    // Sign of the (A_WIDTH+1)-bit signed sum: the operand MSBs travel in the
    // last skew registers, so it is their xor with the final carry.
    assign sum_msb = a_q[NUM_STAGES-1][A_WIDTH-1] ^ b_q[NUM_STAGES-1][A_WIDTH-1]
                   ^ carry[NUM_STAGES-1];
`else
    assign sum_msb = carry[NUM_STAGES-1];
`endif

    assign bus.Sum       = {sum_msb, sum_body};
    assign bus.out_valid = vld[NUM_STAGES-1];
endmodule
